// File: rtl/subtractor_float_iter.sv
// rtl/subtractor_float_iter.sv - iterative IEEE-754 single-precision subtractor y = a - b
//
// Purpose: computes a - b one shift per cycle. The result is truncated, not
// rounded, and denormals are flushed. A NaN or infinity operand gives a quiet NaN.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   operand pair a/b presented
//   in_ready   high only while idle; an operand pair is taken on in_valid & in_ready
//   a, b       IEEE-754 single-precision minuend and subtrahend
//   out_valid  y holds a completed result (high only in DONE)
//   out_ready  consumer accepts y; returns the block to idle
//   y          registered result
module subtractor_float_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    typedef enum logic [2:0] {IDLE, ALIGN, COMBINE, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [23:0] mg_q, mg_d;
    logic [23:0] ml_q, ml_d;
    logic [7:0]  d_q, d_d;
    logic [24:0] sum_q, sum_d;
    logic [7:0]  e_q, e_d;
    logic        sign_q, sign_d;
    logic        eff_sub_q, eff_sub_d;
    logic        nan_q, nan_d;
    logic [31:0] y_q, y_d;

    // Operand decode, used only on the accept edge.
    logic [31:0] b_neg;
    logic [31:0] g_op;
    logic [30:0] l_mag;
    logic        a_big;
    logic [7:0]  g_exp, l_exp, exp_diff;
    logic [23:0] g_man, l_man;
    logic        nan_in;
    logic [24:0] sum_calc;

    always_comb begin
        b_neg    = {~b[31], b[30:0]};
        a_big    = (a[30:0] >= b_neg[30:0]);
        g_op     = a_big ? a : b_neg;
        l_mag    = a_big ? b_neg[30:0] : a[30:0];
        g_exp    = g_op[30:23];
        l_exp    = l_mag[30:23];
        // A zero exponent means zero or denormal; both contribute nothing.
        g_man    = (g_exp == 8'd0) ? 24'd0 : {1'b1, g_op[22:0]};
        l_man    = (l_exp == 8'd0) ? 24'd0 : {1'b1, l_mag[22:0]};
        // g has the larger magnitude, so its exponent is never smaller.
        exp_diff = g_exp - l_exp;
        nan_in   = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    end

    // The magnitude ordering guarantees mg >= ml, so the difference never wraps.
    always_comb begin
        if (eff_sub_q) begin
            sum_calc = {1'b0, mg_q} - {1'b0, ml_q};
        end else begin
            sum_calc = {1'b0, mg_q} + {1'b0, ml_q};
        end
    end

    always_comb begin
        state_d   = state_q;
        mg_d      = mg_q;
        ml_d      = ml_q;
        d_d       = d_q;
        sum_d     = sum_q;
        e_d       = e_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        nan_d     = nan_q;
        y_d       = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = ALIGN;
                    mg_d      = g_man;
                    sign_d    = g_op[31];
                    // Compare the signs of a and b', not g and b'. When b' is
                    // the larger operand, g and b' always share a sign.
                    eff_sub_d = a[31] ^ b_neg[31];
                    e_d       = g_exp;
                    nan_d     = nan_in;
                    if (exp_diff > 8'd24) begin
                        // The smaller operand would shift out entirely.
                        ml_d = 24'd0;
                        d_d  = 8'd0;
                    end else begin
                        ml_d = l_man;
                        d_d  = exp_diff;
                    end
                end
            end
            ALIGN: begin
                // A NaN operand is resolved in the first ALIGN cycle, so its
                // result appears one edge after accept.
                if (nan_q) begin
                    y_d     = 32'h7FC0_0000;
                    state_d = DONE;
                end else if (d_q == 8'd0) begin
                    state_d = COMBINE;
                end else begin
                    ml_d = ml_q >> 1;
                    d_d  = d_q - 8'd1;
                end
            end
            COMBINE: begin
                sum_d = sum_calc;
                if (sum_calc == 25'd0) begin
                    y_d     = 32'h0000_0000;
                    state_d = DONE;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (sum_q[24]) begin
                    sum_d   = sum_q >> 1;
                    e_d     = e_q + 8'd1;
                    state_d = DONE;
                    if (e_q == 8'd254) begin
                        y_d = {sign_q, 8'hFF, 23'd0};
                    end else begin
                        y_d = {sign_q, e_q + 8'd1, sum_q[23:1]};
                    end
                end else if (sum_q[23]) begin
                    y_d     = {sign_q, e_q, sum_q[22:0]};
                    state_d = DONE;
                end else begin
                    sum_d = sum_q << 1;
                    e_d   = e_q - 8'd1;
                    // If this shift drives the exponent to zero, the result is
                    // below the normal range and is flushed to zero.
                    if (e_q == 8'd1) begin
                        y_d     = {sign_q, 31'd0};
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mg_q      <= 24'd0;
            ml_q      <= 24'd0;
            d_q       <= 8'd0;
            sum_q     <= 25'd0;
            e_q       <= 8'd0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            nan_q     <= 1'b0;
            y_q       <= 32'd0;
        end else begin
            state_q   <= state_d;
            mg_q      <= mg_d;
            ml_q      <= ml_d;
            d_q       <= d_d;
            sum_q     <= sum_d;
            e_q       <= e_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            nan_q     <= nan_d;
            y_q       <= y_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;

endmodule

// File: tb/tb_subtractor_float_iter.sv
// tb/tb_subtractor_float_iter.sv - scoreboard testbench for subtractor_float_iter
module tb_subtractor_float_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;

    subtractor_float_iter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] y;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the IEEE fields.
    task automatic model(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] ey, output int el);
        logic [31:0] bp, g, l;
        int ge, le, d, mg, mlv, s, e, k;
        logic sg;
        bp = {~bv[31], bv[30:0]};
        if (av[30:23] == 8'hFF || bv[30:23] == 8'hFF) begin
            ey = 32'h7FC0_0000;
            el = 1;
            return;
        end
        if (av[30:0] >= bp[30:0]) begin g = av; l = bp; end
        else begin g = bp; l = av; end
        sg  = g[31];
        ge  = int'(g[30:23]);
        le  = int'(l[30:23]);
        mg  = (ge == 0) ? 0 : (1 << 23) + int'(g[22:0]);
        mlv = (le == 0) ? 0 : (1 << 23) + int'(l[22:0]);
        d   = ge - le;
        if (d > 24) begin mlv = 0; d = 0; end
        mlv = mlv >> d;
        s = (av[31] != bp[31]) ? mg - mlv : mg + mlv;
        if (s == 0) begin
            ey = 32'd0;
            el = d + 2;
        end else if (s >= (1 << 24)) begin
            e = ge + 1;
            s = s >> 1;
            ey = (e == 255) ? {sg, 8'hFF, 23'd0} : {sg, 8'(e), 23'(s)};
            el = d + 3;
        end else begin
            e = ge;
            k = 0;
            while (s < (1 << 23)) begin
                s = s << 1;
                e--;
                k++;
                if (e == 0) break;
            end
            if (e == 0) begin
                ey = {sg, 31'd0};
                el = d + 2 + k;
            end else begin
                ey = {sg, 8'(e), 23'(s)};
                el = d + 3 + k;
            end
        end
    endtask

    // Monitor: pops on each new result, checks value, latency, hold stability.
    initial begin
        logic        ov_prev;
        logic [31:0] held;
        exp_t        ex;
        ov_prev = 1'b0;
        held    = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!ov_prev) begin
                        if (sbq.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_out_valid: got y=%h with no pending operation", y);
                        end else begin
                            ex = sbq.pop_front();
                            chk("result_y", y, ex.y);
                            chk("latency", 32'(cyc - ex.acc), 32'(ex.lat));
                        end
                        held = y;
                    end else begin
                        chk("y_stable", y, held);
                    end
                    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                end
                ov_prev = out_valid;
            end
        end
    end

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic use_given, input logic [31:0] gy,
                          input int glat, input int hold);
        logic [31:0] ey;
        int          el;
        exp_t        ex;
        int          t;
        model(av, bv, ey, el);
        if (use_given) begin
            ey = gy;
            el = glat;
        end
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            return;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        ex.y = ey; ex.lat = el; ex.acc = cyc;
        sbq.push_back(ex);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin @(negedge clk); t++; end
        if (!out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL out_valid_timeout: got 0 expected 1 for a=%h b=%h", av, bv);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("out_valid_hold", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_after_handshake", {31'd0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_operand_pair_b(input logic [31:0] av, input int mode);
        logic [31:0] bv;
        int ea, eb;
        ea = int'(av[30:23]);
        bv = $urandom;
        case (mode)
            0: ;
            1: bv = (($urandom_range(0, 1) == 1) ? av : {~av[31], av[30:0]});
            2: begin
                eb = ea + int'($urandom_range(0, 8)) - 4;
                if (eb < 0) eb = 0;
                if (eb > 254) eb = 254;
                bv[30:23] = 8'(eb);
            end
            default: begin
                eb = ea - int'($urandom_range(20, 40));
                if (eb < 0) eb = 0;
                bv[30:23] = 8'(eb);
            end
        endcase
        return bv;
    endfunction

    initial begin
        logic [31:0] av, bv;
        int mode, t;
        #(500000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] av, bv;
        int mode, t;
        // Reset with in_valid asserted: must be ignored.
        reset = 1'b1;
        in_valid = 1'b1;
        a = 32'h3FC0_0000;
        b = 32'h3F80_0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", y, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_valid_ignored_in_reset", {31'd0, in_ready}, 32'd1);

        run_op(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 4, 0);
        run_op(32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h4000_0000, 3, 1);
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 2, 0);
        run_op(32'h4E80_0000, 32'h3F80_0000, 1'b1, 32'h4E80_0000, 3, 2);
        run_op(32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 1, 5);

        // Abandon an operation mid-alignment with a reset pulse.
        @(negedge clk);
        a = 32'h4B00_0000;
        b = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abandon_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abandon_out_valid", {31'd0, out_valid}, 32'd0);
        run_op(32'h4B00_0000, 32'h3F80_0000, 1'b1, 32'h4AFF_FFFE, 27, 0);

        // Edge cases: infinity from right shift, flush on underflow.
        run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'd0, 0, 0);
        run_op(32'h0080_0001, 32'h0080_0000, 1'b0, 32'd0, 0, 1);
        run_op(32'h4040_0000, 32'h4080_0000, 1'b0, 32'd0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            mode = int'($urandom_range(0, 5));
            av = $urandom;
            if (mode >= 2 && av[30:23] == 8'hFF) av[30:23] = 8'h80;
            if (mode == 4) av[30:23] = 8'($urandom_range(1, 6));
            bv = rand_operand_pair_b(av, (mode > 3) ? 2 : mode);
            run_op(av, bv, 1'b0, 32'd0, 0, int'($urandom_range(0, 3)));
        end

        t = 0;
        while (sbq.size() != 0 && t < 100) begin @(negedge clk); t++; end
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
